// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its pending-write scoreboard.
// Optional write-through bypass is selected with REGFILE_WR_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_wr_decode.sv
// Enabled one-hot index decode; bit 0 is never asserted because x0 is
// hardwired to zero.
module regfile_wr_decode
    import regfile_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        onehot[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with per-register pending-write scoreboard.
// Define REGFILE_WR_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              iss_valid,
    input  logic              iss_we,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              busy_a,
    output logic              busy_b,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-1:0]             busy_q, busy_d;
    logic [NREG-1:0]             wr_hot;
    logic [NREG-1:0]             set_hot;

    regfile_wr_decode u_wr_dec (
        .en     (RegWrite),
        .addr   (wr_addr),
        .onehot (wr_hot)
    );

    regfile_wr_decode u_set_dec (
        .en     (iss_valid & iss_we),
        .addr   (iss_rd),
        .onehot (set_hot)
    );

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREG; i++) begin
            if (wr_hot[i]) begin
                regs_d[i] = wr_data;
            end
        end
        // Set is applied after clear so a younger issue wins on the same index.
        busy_d = (busy_q & ~wr_hot) | set_hot;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data_a = (rd_addr_a == ZERO_REG) ? '0 : regs_q[rd_addr_a];
        rd_data_b = (rd_addr_b == ZERO_REG) ? '0 : regs_q[rd_addr_b];
        busy_a    = busy_q[rd_addr_a];
        busy_b    = busy_q[rd_addr_b];
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_hot[rd_addr_a]) begin
            rd_data_a = wr_data;
            busy_a    = 1'b0;
        end
        if (wr_hot[rd_addr_b]) begin
            rd_data_b = wr_data;
            busy_b    = 1'b0;
        end
`endif
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (both bypass builds).
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        iss_valid;
    logic        iss_we;
    logic [4:0]  iss_rd;
    logic        busy_a;
    logic        busy_b;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_rd    (iss_rd),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ir;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eba;
        logic        ebb;
        logic [31:0] ebv;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        RegWrite  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_we    = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        RegWrite  = v.we;
        wr_addr   = v.wa;
        wr_data   = v.wd;
        iss_valid = v.iss;
        iss_we    = v.iss;
        iss_rd    = v.ir;
        rd_addr_a = v.ra;
        rd_addr_b = v.rb;
        @(posedge clk);
        #1;
        idle();
        #1;
        check($sformatf("v%0d rd_data_a", idx), rd_data_a, v.ea);
        check($sformatf("v%0d rd_data_b", idx), rd_data_b, v.eb);
        check($sformatf("v%0d busy_a", idx), {31'd0, busy_a}, {31'd0, v.eba});
        check($sformatf("v%0d busy_b", idx), {31'd0, busy_b}, {31'd0, v.ebb});
        check($sformatf("v%0d busy_vec", idx), busy_vec, v.ebv);
    endtask

    initial begin
        //          we wa  wd            iss ir  ra  rb  ea            eb            ba bb bv
        tbl[0] = '{1, 5,  32'hDEADBEEF, 0,  0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0};
        tbl[1] = '{1, 0,  32'hFFFFFFFF, 1,  0,  0,  5,  32'h0,        32'hDEADBEEF, 0, 0, 32'h0};
        tbl[2] = '{0, 0,  32'h0,        1,  7,  7,  5,  32'h0,        32'hDEADBEEF, 1, 0, 32'h80};
        tbl[3] = '{1, 7,  32'h12,       0,  0,  7,  7,  32'h12,       32'h12,       0, 0, 32'h0};
        tbl[4] = '{0, 0,  32'h0,        1,  9,  9,  3,  32'h0,        32'h0,        1, 0, 32'h200};
        tbl[5] = '{1, 9,  32'h99,       1,  9,  9,  9,  32'h99,       32'h99,       1, 1, 32'h200};
        tbl[6] = '{1, 9,  32'h55,       1,  3,  3,  9,  32'h0,        32'h55,       1, 0, 32'h8};
        tbl[7] = '{1, 3,  32'h33,       1,  31, 3,  31, 32'h33,       32'h0,        0, 1, 32'h80000000};
        tbl[8] = '{1, 20, 32'hABCD,     0,  0,  20, 31, 32'hABCD,     32'h0,        0, 1, 32'h80000000};
        tbl[9] = '{0, 0,  32'h0,        1,  31, 31, 20, 32'h0,        32'hABCD,     1, 0, 32'h80000000};

        rst_n     = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        idle();

        // Random traffic before reset
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            RegWrite  = 1'b1;
            wr_addr   = 5'($urandom_range(1, 31));
            wr_data   = $urandom;
            iss_valid = 1'b1;
            iss_we    = 1'b1;
            iss_rd    = 5'($urandom_range(1, 31));
        end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        check("reset busy_vec", busy_vec, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check($sformatf("reset rd_a[%0d]", i), rd_data_a, 32'h0);
            check($sformatf("reset rd_b[%0d]", 31 - i), rd_data_b, 32'h0);
            check($sformatf("reset busy_a[%0d]", i), {31'd0, busy_a}, 32'h0);
            check($sformatf("reset busy_b[%0d]", 31 - i), {31'd0, busy_b}, 32'h0);
        end

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i], i);
        end

        // Same-cycle read of an index being written (reg5 = DEADBEEF)
        @(negedge clk);
        RegWrite  = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'h1111;
        rd_addr_a = 5'd5;
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        check("same-cycle rd_a", rd_data_a, 32'h1111);
`else
        check("same-cycle rd_a", rd_data_a, 32'hDEADBEEF);
`endif
        @(posedge clk);
        #1;
        idle();
        #1;
        check("next-cycle rd_a", rd_data_a, 32'h1111);

        // Busy register 12, then write it while reading on port B
        @(negedge clk);
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_rd    = 5'd12;
        rd_addr_b = 5'd12;
        @(negedge clk);
        idle();
        #1;
        check("busy12 busy_b", {31'd0, busy_b}, 32'h1);
        RegWrite = 1'b1;
        wr_addr  = 5'd12;
        wr_data  = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        check("bypass rd_b", rd_data_b, 32'hA5A5A5A5);
        check("bypass busy_b", {31'd0, busy_b}, 32'h0);
`else
        check("no-bypass rd_b", rd_data_b, 32'h0);
        check("no-bypass busy_b", {31'd0, busy_b}, 32'h1);
`endif
        check("write busy_vec", busy_vec, 32'h80001000);
        @(posedge clk);
        #1;
        idle();
        #1;
        check("after write rd_b", rd_data_b, 32'hA5A5A5A5);
        check("after write busy_b", {31'd0, busy_b}, 32'h0);

        // Write and issue coincident with reset are discarded
        @(negedge clk);
        rst_n     = 1'b0;
        RegWrite  = 1'b1;
        wr_addr   = 5'd12;
        wr_data   = 32'h77;
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_rd    = 5'd4;
        @(posedge clk);
        #1;
        idle();
        rst_n     = 1'b1;
        rd_addr_a = 5'd4;
        #1;
        check("rst+write rd_b", rd_data_b, 32'h0);
        check("rst+issue busy_vec", busy_vec, 32'h0);
        check("rst rd_a", rd_data_a, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
